// File: rtl/bpu_gshare_ras.sv
// -----------------------------------------------------------------------------
// bpu_gshare_ras
//   Branch prediction unit for the 5-stage pipeline. It has three parts:
//     * a gshare pattern history table (PHT) of 2-bit counters, indexed by
//       PC xor global history
//     * a direct-mapped, tagged BTB whose entries record the branch type
//     * a circular return address stack (RAS)
//   Lookup is purely combinational from F_pc and reads registered state only.
//   Training comes from EX: at most one resolved control-flow instruction per
//   clock. Its effects become visible to lookup on the following cycle.
//
// Ports
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   F_pc              fetch PC (word aligned)
//   F_pred_taken      predict redirect at fetch
//   F_pred_target     predicted next PC (F_pc+4 when not taken)
//   F_pht_idx         PHT index used for this fetch; travels down to EX
//   F_btb_hit         valid BTB tag match for F_pc
//   ex_update_en      training strobe (already qualified by stall/flush)
//   ex_pc             PC of the resolved instruction
//   ex_pht_idx        F_pht_idx that was carried with that instruction
//   ex_br_type        00 cond, 01 jump, 10 call, 11 return
//   ex_actual_taken   resolved direction (1 for jump/call/return)
//   ex_actual_target  resolved target
// -----------------------------------------------------------------------------
module bpu_gshare_ras #(
   parameter int GHR_W       = 8,
   parameter int BTB_ENTRIES = 16,
   parameter int RAS_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      F_pc,
   output logic             F_pred_taken,
   output logic [31:0]      F_pred_target,
   output logic [GHR_W-1:0] F_pht_idx,
   output logic             F_btb_hit,
   input  logic             ex_update_en,
   input  logic [31:0]      ex_pc,
   input  logic [GHR_W-1:0] ex_pht_idx,
   input  logic [1:0]       ex_br_type,
   input  logic             ex_actual_taken,
   input  logic [31:0]      ex_actual_target
);

   localparam int PHT_ENTRIES = 2 ** GHR_W;
   localparam int IDX_W       = $clog2(BTB_ENTRIES);
   localparam int TAG_W       = 30 - IDX_W;
   localparam int RAS_W       = $clog2(RAS_DEPTH);
   localparam int CNT_W       = RAS_W + 1;

   typedef enum logic [1:0] {
      BR_COND = 2'b00,
      BR_JUMP = 2'b01,
      BR_CALL = 2'b10,
      BR_RET  = 2'b11
   } br_type_e;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      br_type_e         kind;
   } btb_entry_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [GHR_W-1:0] ghr;
   logic [1:0]       pht       [PHT_ENTRIES];
   btb_entry_t       btb       [BTB_ENTRIES];
   logic [31:0]      ras_stack [RAS_DEPTH];
   logic [RAS_W-1:0] ras_ptr;   // points at the current top of stack
   logic [CNT_W-1:0] ras_cnt;   // number of live entries, 0..RAS_DEPTH

   // ---------------------------------------------------------------------------
   // Lookup (IF)
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] f_btb_idx;
   logic [TAG_W-1:0] f_tag;
   btb_entry_t       f_entry;
   logic [31:0]      f_pc_plus4;

   assign f_btb_idx  = F_pc[IDX_W+1:2];
   assign f_tag      = F_pc[31:IDX_W+2];
   assign f_entry    = btb[f_btb_idx];
   assign f_pc_plus4 = F_pc + 32'd4;
   assign F_pht_idx  = F_pc[GHR_W+1:2] ^ ghr;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      F_btb_hit     = 1'b0;
      F_pred_taken  = 1'b0;
      F_pred_target = f_pc_plus4;

      F_btb_hit    = f_entry.valid && (f_entry.tag == f_tag);
      // Only conditional branches consult the direction counter; jumps,
      // calls and returns redirect on every hit.
      F_pred_taken = F_btb_hit &&
                     ((f_entry.kind != BR_COND) || pht[F_pht_idx][1]);

      if (F_pred_taken) begin
         // A return with an empty RAS falls back to the BTB target.
         if ((f_entry.kind == BR_RET) && (ras_cnt != '0))
            F_pred_target = ras_stack[ras_ptr];
         else
            F_pred_target = f_entry.target;
      end
   end

   // ---------------------------------------------------------------------------
   // Training (EX)
   // ---------------------------------------------------------------------------
   br_type_e         ex_kind;
   logic [IDX_W-1:0] ex_btb_idx;
   logic [RAS_W-1:0] ras_ptr_inc;
   logic [RAS_W-1:0] ras_ptr_dec;
   logic [1:0]       ex_ctr;

   assign ex_kind     = br_type_e'(ex_br_type);
   assign ex_btb_idx  = ex_pc[IDX_W+1:2];
   assign ras_ptr_inc = ras_ptr + 1'b1;   // wraps modulo RAS_DEPTH
   assign ras_ptr_dec = ras_ptr - 1'b1;
   assign ex_ctr      = pht[ex_pht_idx];

   // NOTE: all state here uses non-blocking assignments so every read in this
   // block sees the pre-edge value, matching the "same-cycle lookup sees old
   // state" contract and avoiding simulation order races.
   // NOTE: the arrays are reset explicitly (not left as RAM) because lookup
   // must be X-free and fully defined the instant reset asserts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr     <= '0;
         ras_ptr <= '0;
         ras_cnt <= '0;
         for (int i = 0; i < PHT_ENTRIES; i++)
            pht[i] <= 2'b01;   // weak not-taken
         for (int i = 0; i < BTB_ENTRIES; i++)
            btb[i] <= '{valid: 1'b0, tag: '0, target: '0, kind: BR_COND};
         for (int i = 0; i < RAS_DEPTH; i++)
            ras_stack[i] <= '0;
      end else if (ex_update_en) begin
         // Direction history: conditional branches only.
         if (ex_kind == BR_COND) begin
            if (ex_actual_taken) begin
               if (ex_ctr != 2'b11)
                  pht[ex_pht_idx] <= ex_ctr + 2'd1;
            end else begin
               if (ex_ctr != 2'b00)
                  pht[ex_pht_idx] <= ex_ctr - 2'd1;
            end
            ghr <= {ghr[GHR_W-2:0], ex_actual_taken};
         end

         // Any taken instruction allocates or overwrites its BTB slot.
         if (ex_actual_taken)
            btb[ex_btb_idx] <= '{valid:  1'b1,
                                 tag:    ex_pc[31:IDX_W+2],
                                 target: ex_actual_target,
                                 kind:   ex_kind};

         // Return stack. When full, the push overwrites the oldest slot
         // because the pointer simply wraps.
         case (ex_kind)
            BR_CALL: begin
               ras_ptr                <= ras_ptr_inc;
               ras_stack[ras_ptr_inc] <= ex_pc + 32'd4;
               if (ras_cnt != CNT_W'(RAS_DEPTH))
                  ras_cnt <= ras_cnt + 1'b1;
            end
            BR_RET: begin
               if (ras_cnt != '0) begin
                  ras_ptr <= ras_ptr_dec;
                  ras_cnt <= ras_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bpu_gshare_ras.sv
// -----------------------------------------------------------------------------
// tb_bpu_gshare_ras
//   Self-checking bench for bpu_gshare_ras with default parameters.
//   A directed vector table covers reset, gshare training, BTB aliasing and
//   RAS behaviour. Hand-written sequences cover asynchronous reset and a
//   long random run that is compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_bpu_gshare_ras;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] F_pc;
   logic        F_pred_taken;
   logic [31:0] F_pred_target;
   logic [7:0]  F_pht_idx;
   logic        F_btb_hit;
   logic        ex_update_en;
   logic [31:0] ex_pc;
   logic [7:0]  ex_pht_idx;
   logic [1:0]  ex_br_type;
   logic        ex_actual_taken;
   logic [31:0] ex_actual_target;

   always #5 clk = ~clk;

   bpu_gshare_ras #(.GHR_W(8), .BTB_ENTRIES(16), .RAS_DEPTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .F_pc             (F_pc),
      .F_pred_taken     (F_pred_taken),
      .F_pred_target    (F_pred_target),
      .F_pht_idx        (F_pht_idx),
      .F_btb_hit        (F_btb_hit),
      .ex_update_en     (ex_update_en),
      .ex_pc            (ex_pc),
      .ex_pht_idx       (ex_pht_idx),
      .ex_br_type       (ex_br_type),
      .ex_actual_taken  (ex_actual_taken),
      .ex_actual_target (ex_actual_target)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table: one optional update per cycle, then a lookup that
   // observes the post-update state.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        upd;
      logic [31:0] pc;
      logic [7:0]  idx;
      logic [1:0]  typ;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] fpc;
      logic        e_hit;
      logic        e_tk;
      logic [31:0] e_tgt;
      logic [7:0]  e_idx;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic upd, input logic [31:0] pc, input logic [7:0] idx,
                               input logic [1:0] typ, input logic tk, input logic [31:0] tgt,
                               input logic [31:0] fpc, input logic e_hit, input logic e_tk,
                               input logic [31:0] e_tgt, input logic [7:0] e_idx);
      vec_t v;
      v.upd = upd; v.pc = pc; v.idx = idx; v.typ = typ; v.tk = tk; v.tgt = tgt;
      v.fpc = fpc; v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_idx = e_idx;
      vecs.push_back(v);
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model (default parameters)
   // ---------------------------------------------------------------------------
   logic [1:0]  m_pht   [256];
   logic        m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic [1:0]  m_type  [16];
   logic [31:0] m_stack [4];
   int          m_ptr;
   int          m_cnt;
   logic [7:0]  m_ghr;

   function automatic void m_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_type[i] = 2'b00;
      end
      for (int i = 0; i < 4; i++) m_stack[i] = '0;
      m_ptr = 0; m_cnt = 0; m_ghr = '0;
   endfunction

   function automatic logic [41:0] m_lookup(input logic [31:0] pc);
      logic [7:0]  idx;
      logic [3:0]  bi;
      logic        hit, tk;
      logic [31:0] tgt;
      idx = pc[9:2] ^ m_ghr;
      bi  = pc[5:2];
      hit = m_valid[bi] && (m_tag[bi] == pc[31:6]);
      tk  = hit && ((m_type[bi] != 2'b00) || m_pht[idx][1]);
      if (!tk)                                   tgt = pc + 32'd4;
      else if (m_type[bi] == 2'b11 && m_cnt > 0) tgt = m_stack[m_ptr];
      else                                       tgt = m_tgt[bi];
      return {hit, tk, tgt, idx};
   endfunction

   function automatic void m_update(input logic [31:0] pc, input logic [7:0] idx,
                                    input logic [1:0] typ, input logic tk,
                                    input logic [31:0] tgt);
      if (typ == 2'b00) begin
         if (tk && m_pht[idx] < 2'd3)       m_pht[idx] = m_pht[idx] + 2'd1;
         else if (!tk && m_pht[idx] > 2'd0) m_pht[idx] = m_pht[idx] - 2'd1;
         m_ghr = {m_ghr[6:0], tk};
      end
      if (tk) begin
         m_valid[pc[5:2]] = 1'b1;
         m_tag[pc[5:2]]   = pc[31:6];
         m_tgt[pc[5:2]]   = tgt;
         m_type[pc[5:2]]  = typ;
      end
      if (typ == 2'b10) begin
         m_ptr = (m_ptr + 1) % 4;
         m_stack[m_ptr] = pc + 32'd4;
         if (m_cnt < 4) m_cnt++;
      end else if (typ == 2'b11 && m_cnt > 0) begin
         m_ptr = (m_ptr + 3) % 4;
         m_cnt--;
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      // upd  ex_pc         idx    typ    tk  ex_tgt        F_pc          hit tk  exp_tgt       exp_idx
      // reset state
      add(0, 32'h0,        8'h00, 2'b00, 0, 32'h0,        32'h100,      0, 0, 32'h104,      8'h40);
      // gshare training on a cond branch at 0x200 -> 0x180
      add(1, 32'h200,      8'h83, 2'b00, 1, 32'h180,      32'h200,      1, 0, 32'h204,      8'h81);
      add(1, 32'h200,      8'h83, 2'b00, 1, 32'h180,      32'h200,      1, 1, 32'h180,      8'h83);
      add(1, 32'h200,      8'hE1, 2'b00, 0, 32'hDEAD0,    32'h200,      1, 0, 32'h204,      8'h86);
      add(1, 32'h200,      8'hE1, 2'b00, 0, 32'hDEAD0,    32'h200,      1, 0, 32'h204,      8'h8C);
      add(1, 32'h200,      8'hE1, 2'b00, 0, 32'hDEAD0,    32'h200,      1, 0, 32'h204,      8'h98);
      add(1, 32'h200,      8'hE1, 2'b00, 0, 32'hDEAD0,    32'h200,      1, 0, 32'h204,      8'hB0);
      add(1, 32'h200,      8'hE1, 2'b00, 1, 32'h180,      32'h200,      1, 0, 32'h204,      8'hE1);
      // BTB aliasing: 0x40 and 0x80 share index 0
      add(1, 32'h40,       8'h00, 2'b01, 1, 32'h1000,     32'h40,       1, 1, 32'h1000,     8'h71);
      add(1, 32'h80,       8'h00, 2'b01, 1, 32'h2000,     32'h40,       0, 0, 32'h44,       8'h71);
      add(0, 32'h0,        8'h00, 2'b00, 0, 32'h0,        32'h80,       1, 1, 32'h2000,     8'h41);
      // call / return pairing
      add(1, 32'h300,      8'h00, 2'b10, 1, 32'h800,      32'h300,      1, 1, 32'h800,      8'hA1);
      add(1, 32'h810,      8'h00, 2'b11, 1, 32'h77C,      32'h810,      1, 1, 32'h77C,      8'h65);
      add(1, 32'h300,      8'h00, 2'b10, 1, 32'h800,      32'h810,      1, 1, 32'h304,      8'h65);
      add(1, 32'h810,      8'h00, 2'b11, 1, 32'h77C,      32'h810,      1, 1, 32'h77C,      8'h65);
      // RAS overflow / underflow, observed through a return entry at 0x908
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'hABC,      8'h23);
      add(1, 32'h10,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h14,       8'h23);
      add(1, 32'h20,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h24,       8'h23);
      add(1, 32'h30,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h34,       8'h23);
      add(1, 32'h40,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h44,       8'h23);
      add(1, 32'h50,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h54,       8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'h44,       8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'h34,       8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'h24,       8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'hABC,      8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'hABC,      8'h23);
      add(1, 32'h60,       8'h00, 2'b10, 1, 32'h600,      32'h908,      1, 1, 32'h64,       8'h23);
      add(1, 32'h908,      8'h00, 2'b11, 1, 32'hABC,      32'h908,      1, 1, 32'hABC,      8'h23);
      // not-taken next PC wraps at the top of the address space
      add(0, 32'h0,        8'h00, 2'b00, 0, 32'h0,        32'hFFFF_FFFC, 0, 0, 32'h0,       8'h9E);

      rst = 1'b1; F_pc = '0; ex_update_en = 1'b0; ex_pc = '0; ex_pht_idx = '0;
      ex_br_type = '0; ex_actual_taken = 1'b0; ex_actual_target = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         ex_update_en     = vecs[i].upd;
         ex_pc            = vecs[i].pc;
         ex_pht_idx       = vecs[i].idx;
         ex_br_type       = vecs[i].typ;
         ex_actual_taken  = vecs[i].tk;
         ex_actual_target = vecs[i].tgt;
         F_pc             = vecs[i].fpc;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_hit", i), 64'(F_btb_hit),     64'(vecs[i].e_hit));
         check($sformatf("v%0d_tk",  i), 64'(F_pred_taken),  64'(vecs[i].e_tk));
         check($sformatf("v%0d_tgt", i), 64'(F_pred_target), 64'(vecs[i].e_tgt));
         check($sformatf("v%0d_idx", i), 64'(F_pht_idx),     64'(vecs[i].e_idx));
      end

      // Same-cycle lookup sees old state: before the edge, 0x700 still misses.
      @(negedge clk);
      ex_update_en = 1'b1; ex_pc = 32'h700; ex_br_type = 2'b01;
      ex_actual_taken = 1'b1; ex_actual_target = 32'h3000; F_pc = 32'h700;
      #1;
      check("same_cycle_old", 64'(F_btb_hit), 64'd0);
      @(posedge clk);
      #1;
      check("next_cycle_new", 64'(F_pred_target), 64'h3000);

      // Asynchronous reset between edges while an update is pending.
      @(negedge clk);
      ex_update_en = 1'b1; ex_pc = 32'h100; ex_br_type = 2'b01;
      ex_actual_taken = 1'b1; ex_actual_target = 32'h4000; F_pc = 32'h100;
      #2;
      rst = 1'b1;
      #1;
      check("arst_hit", 64'(F_btb_hit),     64'd0);
      check("arst_tk",  64'(F_pred_taken),  64'd0);
      check("arst_tgt", 64'(F_pred_target), 64'h104);
      check("arst_idx", 64'(F_pht_idx),     64'h40);
      @(posedge clk);
      #1;
      check("arst_drop", 64'(F_btb_hit), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ex_update_en = 1'b0;
      F_pc = 32'h700;
      #1;
      check("arst_cleared", 64'(F_btb_hit), 64'd0);

      // Random run against the reference model.
      m_reset();
      for (int n = 0; n < 10000; n++) begin
         logic [31:0] rpc;
         @(negedge clk);
         rpc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                            : 32'h1000 + (32'($urandom_range(0, 31)) << 2);
         ex_update_en     = ($urandom_range(0, 3) != 0);
         ex_pc            = rpc;
         ex_br_type       = 2'($urandom_range(0, 3));
         ex_actual_taken  = (ex_br_type != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
         ex_actual_target = $urandom & 32'hFFFF_FFFC;
         ex_pht_idx       = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                        : (rpc[9:2] ^ m_ghr);
         F_pc             = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                                         : 32'h1000 + (32'($urandom_range(0, 31)) << 2);
         #1;
         check("rand", 64'({F_btb_hit, F_pred_taken, F_pred_target, F_pht_idx}),
               64'(m_lookup(F_pc)));
         @(posedge clk);
         if (ex_update_en)
            m_update(ex_pc, ex_pht_idx, ex_br_type, ex_actual_taken, ex_actual_target);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
